// File: rtl/vt512_pkg.sv
// VT512 DT24 ingest: shared opcodes, states and header/config field layout.
// Imported by the ingest controller and its raster counter.
package vt512_pkg;

    typedef enum logic [3:0] {
        OP_CONFIG  = 4'd1,
        OP_WEIGHTS = 4'd2,
        OP_BIASES  = 4'd3,
        OP_IMAGE   = 4'd4
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_WEIGHTS,
        S_BIASES,
        S_IMAGE
    } state_t;

    localparam int HDR_OP_LSB  = 0;
    localparam int HDR_ARG_LSB = 4;
    localparam int CFG_CH_LSB  = 0;
    localparam int CFG_REUSE_W = 4;
    localparam int CFG_REUSE_B = 5;

    // Out-of-range channel counts fall back to a single channel.
    function automatic logic [3:0] active_chans(
        input logic [3:0] c,
        input int         n
    );
        return (c == 4'd0 || c > 4'(n)) ? 4'd1 : c;
    endfunction

endpackage

// File: rtl/vt512_raster_counter.sv
// Channel/column/row raster counter for pixel-interleaved row-major images.
// Channel steps fastest, then column, then row.
module vt512_raster_counter #(
    parameter int SIZE_LOG2 = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               step,
    input  logic [3:0]         chans,
    input  logic [SIZE_LOG2:0] side,
    output logic [3:0]         ch,
    output logic [SIZE_LOG2:0] col,
    output logic [SIZE_LOG2:0] row,
    output logic               last
);

    localparam int W = SIZE_LOG2 + 1;

    logic ch_end;
    logic col_end;
    logic row_end;

    assign ch_end  = (ch == chans - 4'd1);
    assign col_end = (col == side - W'(1));
    assign row_end = (row == side - W'(1));
    assign last    = ch_end && col_end && row_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (clear) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (!ch_end) begin
                ch <= ch + 4'd1;
            end else begin
                ch <= '0;
                if (!col_end) begin
                    col <= col + W'(1);
                end else begin
                    col <= '0;
                    row <= row + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vt512_dt24_ingress.sv
// DT24 ingest controller: decodes header words and streams payloads into
// the config register and the weight, bias and per-channel image stores.
module vt512_dt24_ingress
    import vt512_pkg::*;
#(
    parameter int DATA_WIDTH          = 24,
    parameter int NUM_CHANNELS        = 3,
    parameter int MAX_IMAGE_SIZE      = 512,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9,
    parameter int WEIGHT_DEPTH        = 256,
    parameter int BIAS_DEPTH          = 64
) (
    input  logic                             dt24_clk_i,
    input  logic                             dt24_rst_ni,
    input  logic                             dt24_we_i,
    input  logic [DATA_WIDTH-1:0]            dt24_data_i,
    input  logic                             abort_i,
    output logic [DATA_WIDTH-1:0]            cfg_o,
    output logic                             cfg_valid_o,
    output logic                             wgt_we_o,
    output logic [$clog2(WEIGHT_DEPTH)-1:0]  wgt_addr_o,
    output logic [DATA_WIDTH-1:0]            wgt_data_o,
    output logic                             bias_we_o,
    output logic [$clog2(BIAS_DEPTH)-1:0]    bias_addr_o,
    output logic [DATA_WIDTH-1:0]            bias_data_o,
    output logic [NUM_CHANNELS-1:0]          img_we_o,
    output logic [MAX_IMAGE_SIZE_LOG2:0]     img_row_o,
    output logic [MAX_IMAGE_SIZE_LOG2:0]     img_col_o,
    output logic [DATA_WIDTH-1:0]            img_data_o,
    output logic [MAX_IMAGE_SIZE_LOG2:0]     image_size_o,
    output logic                             image_done_o,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int AW    = $clog2(WEIGHT_DEPTH);
    localparam int BW    = $clog2(BIAS_DEPTH);
    localparam int IW    = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int ARG_W = DATA_WIDTH - HDR_ARG_LSB;

    state_t           state;
    state_t           state_n;
    logic [3:0]       op;
    logic [ARG_W-1:0] arg;
    logic [IW-1:0]    side;
    logic             side_ok;
    logic [ARG_W-1:0] cnt;
    logic [ARG_W-1:0] len;
    logic             last_word;
    logic [3:0]       chans;
    logic             cfg_bad;
    logic [3:0]       ch;
    logic [IW-1:0]    row;
    logic [IW-1:0]    col;
    logic             px_last;
    logic             px_step;
    logic             px_clear;

    assign op        = dt24_data_i[HDR_ARG_LSB-1:HDR_OP_LSB];
    assign arg       = dt24_data_i[DATA_WIDTH-1:HDR_ARG_LSB];
    assign side      = arg[IW-1:0];
    assign side_ok   = (side != '0) && (side <= IW'(MAX_IMAGE_SIZE));
    assign last_word = (cnt == len - ARG_W'(1));
    assign chans     = active_chans(cfg_o[CFG_CH_LSB+:4], NUM_CHANNELS);
    assign cfg_bad   = (dt24_data_i[3:0] == 4'd0) ||
                       (dt24_data_i[3:0] > 4'(NUM_CHANNELS));

    assign px_step  = (state == S_IMAGE) && dt24_we_i && !abort_i;
    assign px_clear = abort_i || (state == S_IDLE);

    vt512_raster_counter #(
        .SIZE_LOG2 (MAX_IMAGE_SIZE_LOG2)
    ) u_raster (
        .clk   (dt24_clk_i),
        .rst_n (dt24_rst_ni),
        .clear (px_clear),
        .step  (px_step),
        .chans (chans),
        .side  (image_size_o),
        .ch    (ch),
        .col   (col),
        .row   (row),
        .last  (px_last)
    );

    always_comb begin
        state_n = state;
        if (abort_i) begin
            state_n = S_IDLE;
        end else if (dt24_we_i) begin
            unique case (state)
                S_IDLE: begin
                    case (op)
                        OP_CONFIG:  state_n = S_CONFIG;
                        OP_WEIGHTS: if (arg != '0) state_n = S_WEIGHTS;
                        OP_BIASES:  if (arg != '0) state_n = S_BIASES;
                        OP_IMAGE:   if (side_ok) state_n = S_IMAGE;
                        default:    state_n = S_IDLE;
                    endcase
                end
                S_CONFIG:  state_n = S_IDLE;
                S_WEIGHTS,
                S_BIASES:  if (last_word) state_n = S_IDLE;
                S_IMAGE:   if (px_last) state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge dt24_clk_i or negedge dt24_rst_ni) begin
        if (!dt24_rst_ni) begin
            state        <= S_IDLE;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            cnt          <= '0;
            len          <= '0;
            cfg_o        <= '0;
            cfg_valid_o  <= 1'b0;
            wgt_we_o     <= 1'b0;
            wgt_addr_o   <= '0;
            wgt_data_o   <= '0;
            bias_we_o    <= 1'b0;
            bias_addr_o  <= '0;
            bias_data_o  <= '0;
            img_we_o     <= '0;
            img_row_o    <= '0;
            img_col_o    <= '0;
            img_data_o   <= '0;
            image_size_o <= '0;
            image_done_o <= 1'b0;
        end else begin
            state        <= state_n;
            busy_o       <= (state_n != S_IDLE);
            cfg_valid_o  <= 1'b0;
            wgt_we_o     <= 1'b0;
            bias_we_o    <= 1'b0;
            img_we_o     <= '0;
            image_done_o <= 1'b0;
            if (abort_i) begin
                cnt <= '0;
                len <= '0;
            end else if (dt24_we_i) begin
                unique case (state)
                    S_IDLE: begin
                        cnt <= '0;
                        len <= arg;
                        case (op)
                            OP_CONFIG, OP_WEIGHTS, OP_BIASES: ;
                            OP_IMAGE: begin
                                if (side_ok) image_size_o <= side;
                                else         err_o        <= 1'b1;
                            end
                            default: err_o <= 1'b1;
                        endcase
                    end
                    S_CONFIG: begin
                        cfg_o       <= dt24_data_i;
                        cfg_valid_o <= 1'b1;
                        err_o       <= cfg_bad;
                    end
                    S_WEIGHTS: begin
                        cnt <= cnt + ARG_W'(1);
                        if (cnt < ARG_W'(WEIGHT_DEPTH)) begin
                            wgt_we_o   <= ~cfg_o[CFG_REUSE_W];
                            wgt_addr_o <= cnt[AW-1:0];
                            wgt_data_o <= dt24_data_i;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    S_BIASES: begin
                        cnt <= cnt + ARG_W'(1);
                        if (cnt < ARG_W'(BIAS_DEPTH)) begin
                            bias_we_o   <= ~cfg_o[CFG_REUSE_B];
                            bias_addr_o <= cnt[BW-1:0];
                            bias_data_o <= dt24_data_i;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    S_IMAGE: begin
                        img_we_o     <= NUM_CHANNELS'(1) << ch;
                        img_row_o    <= row;
                        img_col_o    <= col;
                        img_data_o   <= dt24_data_i;
                        image_done_o <= px_last;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vt512_dt24_ingress.sv
// Directed-vector bench for the DT24 ingest controller.
// Expected values are hand-computed from the header/payload layout.
module tb_vt512_dt24_ingress;

    localparam int DW = 24;
    localparam int NC = 3;
    localparam int IW = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          we    = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] data  = '0;

    logic [DW-1:0] cfg;
    logic          cfg_valid;
    logic          wgt_we;
    logic [7:0]    wgt_addr;
    logic [DW-1:0] wgt_data;
    logic          bias_we;
    logic [5:0]    bias_addr;
    logic [DW-1:0] bias_data;
    logic [NC-1:0] img_we;
    logic [IW-1:0] img_row;
    logic [IW-1:0] img_col;
    logic [DW-1:0] img_data;
    logic [IW-1:0] isz;
    logic          done;
    logic          busy;
    logic          err;

    int checks   = 0;
    int failures = 0;
    int n_wgt    = 0;
    int n_bias   = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    vt512_dt24_ingress dut (
        .dt24_clk_i   (clk),
        .dt24_rst_ni  (rst_n),
        .dt24_we_i    (we),
        .dt24_data_i  (data),
        .abort_i      (abort),
        .cfg_o        (cfg),
        .cfg_valid_o  (cfg_valid),
        .wgt_we_o     (wgt_we),
        .wgt_addr_o   (wgt_addr),
        .wgt_data_o   (wgt_data),
        .bias_we_o    (bias_we),
        .bias_addr_o  (bias_addr),
        .bias_data_o  (bias_data),
        .img_we_o     (img_we),
        .img_row_o    (img_row),
        .img_col_o    (img_col),
        .img_data_o   (img_data),
        .image_size_o (isz),
        .image_done_o (done),
        .busy_o       (busy),
        .err_o        (err)
    );

    always @(negedge clk) begin
        if (wgt_we)  n_wgt++;
        if (bias_we) n_bias++;
        if (done)    n_done++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] w);
        data = w;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_cfg", cfg, 0);
        check("rst_isz", isz, 0);
        check("rst_strb", {wgt_we, bias_we, img_we, cfg_valid, done}, 0);
        rst_n = 1'b1;
        tick(1);

        send(24'h000001);
        check("cfg_busy", busy, 1);
        send(24'h000003);
        check("cfg_o", cfg, 24'h3);
        check("cfg_vld", cfg_valid, 1);
        check("cfg_idle", busy, 0);
        tick(1);
        check("cfg_vld0", cfg_valid, 0);

        send(24'h000024);
        check("img_isz", isz, 2);
        check("img_busy", busy, 1);
        base = n_done;
        for (int i = 0; i < 12; i++) begin
            send(DW'(i + 1));
            check($sformatf("px%0d", i),
                  {img_we, img_row, img_col, img_data, done},
                  {3'(1 << (i % 3)), 10'(i / 6), 10'((i / 3) % 2),
                   24'(i + 1), 1'(i == 11)});
        end
        tick(1);
        check("img_done_n", n_done - base, 1);
        check("img_idle", busy, 0);

        send(24'h000044);
        for (int i = 0; i < 10; i++) send(DW'(24'h50 + i));
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_err", err, 0);
        check("mid_strb", {img_we, done}, 0);
        check("mid_isz", isz, 0);
        check("mid_cfg", cfg, 0);
        check("mid_addr", {img_row, img_col, img_data}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        send(24'h000001);
        send(24'h000003);
        send(24'h001022);
        check("w_busy", busy, 1);
        base = n_wgt;
        for (int i = 0; i < 258; i++) begin
            send(DW'(24'h100 + i));
            if (i == 0 || i == 1 || i == 255)
                check($sformatf("w%0d", i), {wgt_we, wgt_addr, wgt_data},
                      {1'b1, 8'(i), 24'(24'h100 + i)});
            if (i == 255) check("w_err0", err, 0);
            if (i == 256) check("w_ovf_we", wgt_we, 0);
            if (i == 256) check("w_ovf_err", err, 1);
        end
        check("w_idle", busy, 0);
        tick(1);
        check("w_count", n_wgt - base, 256);

        send(24'h000001);
        send(24'h000013);
        check("rw_err", err, 0);
        base = n_wgt;
        send(24'h000042);
        for (int i = 0; i < 4; i++) send(DW'(24'h900 + i));
        check("rw_idle", busy, 0);
        tick(1);
        check("rw_count", n_wgt - base, 0);
        send(24'h000013);
        check("b1_busy", busy, 1);
        send(24'h000abc);
        check("b1_wr", {bias_we, bias_addr, bias_data},
              {1'b1, 6'd0, 24'habc});
        check("b1_idle", busy, 0);

        send(24'h000014);
        check("s1_isz", isz, 1);
        for (int i = 0; i < 3; i++) begin
            send(DW'(24'h11 * (i + 1)));
            check($sformatf("s1px%0d", i),
                  {img_we, img_row, img_col, img_data, done},
                  {3'(1 << i), 10'd0, 10'd0, 24'(24'h11 * (i + 1)),
                   1'(i == 2)});
        end

        send(24'h002014);
        check("s513_busy", busy, 0);
        check("s513_err", err, 1);
        check("s513_isz", isz, 1);
        send(24'h000001);
        send(24'h000013);
        check("clr_err", err, 0);
        send(24'h000007);
        check("op7_busy", busy, 0);
        check("op7_err", err, 1);

        base = n_bias;
        send(24'h000083);
        check("ab_busy", busy, 1);
        send(24'h000301);
        check("ab_w0", {bias_we, bias_addr, bias_data}, {1'b1, 6'd0, 24'h301});
        tick(2);
        check("ab_gap", bias_we, 0);
        send(24'h000302);
        check("ab_w1", {bias_we, bias_addr, bias_data}, {1'b1, 6'd1, 24'h302});
        tick(1);
        send(24'h000303);
        check("ab_w2", {bias_we, bias_addr, bias_data}, {1'b1, 6'd2, 24'h303});
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("ab_idle", busy, 0);
        check("ab_strb", bias_we, 0);
        check("ab_err", err, 1);
        tick(1);
        check("ab_count", n_bias - base, 3);

        abort = 1'b1;
        data  = 24'h000001;
        we    = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        we    = 1'b0;
        check("abh_busy", busy, 0);
        send(24'h000003);
        check("abh_vld", cfg_valid, 0);
        check("abh_cfg", cfg, 24'h13);
        check("abh_busy2", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
